// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/collect stage wrapped around a 16-bit ALU slice.
// Takes requests over a valid/ready handshake, drives the ALU, captures its
// flags and returns a registered response. ADD32/SUB32 run as two passes,
// with the low-pass carry-out fed into the high-pass carry-in.
// Optional build macro: ALU_SEQ_STICKY_OVF_EN adds sticky_clr/sticky_ovf.
module alu_op_sequencer #(
    parameter int unsigned ALU_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_cmd,
    input  logic [2*ALU_W-1:0]   req_a,
    input  logic [2*ALU_W-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*ALU_W-1:0]   rsp_result,
    output logic                 rsp_cout,
    output logic                 rsp_overflow,
    output logic                 rsp_zero,
    output logic [ALU_W-1:0]     alu_a,
    output logic [ALU_W-1:0]     alu_b,
    output logic                 alu_cin,
    output logic                 alu_less,
    output logic [2:0]           alu_op,
    input  logic [ALU_W-1:0]     alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_overflow,
    input  logic                 alu_zero,
    input  logic                 alu_set
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    input  logic                 sticky_clr,
    output logic                 sticky_ovf
`endif
);

    localparam int unsigned DW = 2 * ALU_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_AND   = 3'b000,
        CMD_OR    = 3'b001,
        CMD_ADD   = 3'b010,
        CMD_SUB   = 3'b011,
        CMD_SLT   = 3'b100,
        CMD_ADD32 = 3'b101,
        CMD_SUB32 = 3'b110,
        CMD_CMP   = 3'b111
    } cmd_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q,   cmd_d;
    logic [DW-1:0]    a_q,     a_d;
    logic [DW-1:0]    b_q,     b_d;
    logic [DW-1:0]    res_q,   res_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;
    logic             zero_q,  zero_d;
    alu_op_t          op_sel;

    // Signed less-than correction; alu_set never depends on alu_less, so no loop.
    assign alu_less = alu_set ^ alu_overflow;

    assign alu_op       = op_sel;
    assign rsp_result   = res_q;
    assign rsp_cout     = cout_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;

    // State and datapath registers; reset discards any in-flight op or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_AND;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state, ALU drive and result capture for each pass.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        op_sel    = OP_AND;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_d   = cmd_t'(req_cmd);
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = S_LO;
                end
            end

            S_LO: begin
                alu_a = a_q[ALU_W-1:0];
                alu_b = b_q[ALU_W-1:0];
                case (cmd_q)
                    CMD_AND:   op_sel = OP_AND;
                    CMD_OR:    op_sel = OP_OR;
                    CMD_ADD:   op_sel = OP_ADD;
                    CMD_ADD32: op_sel = OP_ADD;
                    CMD_SLT: begin
                        op_sel  = OP_SLT;
                        alu_cin = 1'b1;
                    end
                    CMD_SUB, CMD_SUB32, CMD_CMP: begin
                        op_sel  = OP_SUB;
                        alu_cin = 1'b1;
                    end
                    default: op_sel = OP_AND;
                endcase

                res_d              = '0;
                res_d[ALU_W-1:0]   = alu_result;
                cout_d             = alu_cout;
                ovf_d              = alu_overflow;
                zero_d             = alu_zero;

                case (cmd_q)
                    CMD_AND, CMD_OR: begin
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                    CMD_SLT: begin
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                        zero_d = (alu_result == '0);
                    end
                    CMD_CMP: res_d = '0;
                    default: ;
                endcase

                if (cmd_q == CMD_ADD32 || cmd_q == CMD_SUB32) begin
                    state_d = S_HI;
                end else begin
                    state_d = S_RESP;
                end
            end

            S_HI: begin
                alu_a   = a_q[DW-1:ALU_W];
                alu_b   = b_q[DW-1:ALU_W];
                op_sel  = (cmd_q == CMD_SUB32) ? OP_SUB : OP_ADD;
                // cout_q still holds the low-pass carry here.
                alu_cin = cout_q;
                res_d[DW-1:ALU_W] = alu_result;
                cout_d  = alu_cout;
                ovf_d   = alu_overflow;
                zero_d  = zero_q & alu_zero;
                state_d = S_RESP;
            end

            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

`ifdef ALU_SEQ_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: set by a delivered overflowing response; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (state_q == S_RESP && rsp_ready && ovf_q) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural 16-bit ALU on the ALU side,
// directed plus randomized requests checked against an arithmetic model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic        alu_less;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        alu_overflow;
    logic        alu_zero;
    logic        alu_set;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ALU_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_less     (alu_less),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_set      (alu_set)
    );

    // Behavioural ALU slice: subtract/SLT invert b, adder is a + b' + cin.
    logic [15:0] alu_bop;
    logic [16:0] alu_sum;
    assign alu_bop      = (alu_op == 3'b110 || alu_op == 3'b111) ? ~alu_b : alu_b;
    assign alu_sum      = {1'b0, alu_a} + {1'b0, alu_bop} + {16'h0, alu_cin};
    assign alu_cout     = alu_sum[16];
    assign alu_set      = alu_sum[15];
    assign alu_overflow = alu_op[1] & (alu_a[15] == alu_bop[15]) & (alu_sum[15] != alu_a[15]);
    assign alu_zero     = (alu_result == 16'h0);

    always_comb begin
        alu_result = 16'h0;
        case (alu_op)
            3'b000:         alu_result = alu_a & alu_b;
            3'b001:         alu_result = alu_a | alu_b;
            3'b010, 3'b110: alu_result = alu_sum[15:0];
            3'b111:         alu_result = {15'h0, alu_less};
            default:        alu_result = 16'h0;
        endcase
    end

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    // Expected response from plain integer arithmetic on the request.
    function automatic exp_t ref_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [15:0] a16, b16;
        int          sa, sb, sd;
        longint      la, lb, ld;
        logic [32:0] w;
        a16 = a[15:0];
        b16 = b[15:0];
        sa  = $signed(a16);
        sb  = $signed(b16);
        la  = $signed(a);
        lb  = $signed(b);
        e   = '0;
        case (cmd)
            3'd0: e.res = {16'h0, a16 & b16};
            3'd1: e.res = {16'h0, a16 | b16};
            3'd2: begin
                e.res = {16'h0, a16 + b16};
                e.c   = (32'(a16) + 32'(b16)) > 32'hFFFF;
                sd    = sa + sb;
                e.v   = (sd > 32767) || (sd < -32768);
            end
            3'd3, 3'd7: begin
                e.res = (cmd == 3'd3) ? {16'h0, a16 - b16} : 32'h0;
                e.c   = (a16 >= b16);
                sd    = sa - sb;
                e.v   = (sd > 32767) || (sd < -32768);
            end
            3'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: begin
                e.res = a + b;
                w     = {1'b0, a} + {1'b0, b};
                e.c   = w[32];
                ld    = la + lb;
                e.v   = (ld > 64'sd2147483647) || (ld < -64'sd2147483648);
            end
            default: begin
                e.res = a - b;
                e.c   = (a >= b);
                ld    = la - lb;
                e.v   = (ld > 64'sd2147483647) || (ld < -64'sd2147483648);
            end
        endcase
        e.z = (cmd == 3'd7) ? (a16 == b16) : (e.res == 32'h0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction from IDLE, with `stall` cycles of response backpressure.
    task automatic run_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned stall);
        exp_t        e;
        int unsigned lat;
        int unsigned want;
        e    = ref_op(cmd, a, b);
        want = (cmd == 3'd5 || cmd == 3'd6) ? 3 : 2;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_alu_op", 32'(alu_op), 32'd0);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat       = 1;
        check("busy_req_ready", 32'(req_ready), 32'd0);
        while (!rsp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, want);
        for (int unsigned i = 0; i < stall; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", rsp_result, e.res);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            req_valid = 1'($urandom_range(0, 1));
            req_cmd   = 3'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_result", rsp_result, e.res);
        check("rsp_cout", 32'(rsp_cout), 32'(e.c));
        check("rsp_overflow", 32'(rsp_overflow), 32'(e.v));
        check("rsp_zero", 32'(rsp_zero), 32'(e.z));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [8];
        corners = '{32'h0, 32'h1, 32'h7FFF, 32'h8000, 32'hFFFF,
                    32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) begin
            return corners[$urandom_range(0, 7)];
        end
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'h0);
        check("reset_rsp_flags", {29'h0, rsp_cout, rsp_overflow, rsp_zero}, 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'd1);

        run_op(3'd2, 32'h0000_7FFF, 32'h0000_0001, 0);
        run_op(3'd5, 32'h0001_FFFF, 32'h0000_0001, 0);
        run_op(3'd6, 32'h0000_0000, 32'h0000_0001, 1);
        run_op(3'd7, 32'h0000_1234, 32'h0000_1234, 0);
        run_op(3'd4, 32'h0000_FFFF, 32'h0000_0001, 0);
        run_op(3'd4, 32'h0000_8000, 32'h0000_7FFF, 0);
        run_op(3'd4, 32'h0000_0005, 32'h0000_0003, 0);
        run_op(3'd0, 32'hABCD_F0F0, 32'h1234_0FF0, 2);
        run_op(3'd1, 32'h0000_0000, 32'h0000_0000, 0);
        run_op(3'd3, 32'h0000_0003, 32'h0000_0005, 0);
        run_op(3'd2, 32'h0000_1111, 32'h0000_2222, 5);

        // Reset while the high pass of an ADD32 is in flight.
        req_valid = 1'b1;
        req_cmd   = 3'd5;
        req_a     = 32'h0001_FFFF;
        req_b     = 32'h0000_0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("hi_cin_from_lo_cout", 32'(alu_cin), 32'd1);
        check("hi_alu_a", 32'(alu_a), 32'h0001);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_hi_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_hi_rsp_result", rsp_result, 32'h0);
        check("rst_hi_rsp_flags", {29'h0, rsp_cout, rsp_overflow, rsp_zero}, 32'h0);
        check("rst_hi_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_hi_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_op(3'd2, 32'h0000_0002, 32'h0000_0003, 0);

        for (int n = 0; n < 200; n++) begin
            run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/collect stage placed directly around the 16-bit carry-lookahead ALU datapath.
- Accepts operation requests over a valid/ready handshake and drives the ALU's a/b/cin/less/op inputs.
- Captures the ALU's result, cout, overflow and zero outputs and returns a registered response over a second valid/ready handshake.
- Sequences 32-bit add/subtract as two 16-bit passes, carrying cout from the low pass into cin of the high pass.

Parameters:
ALU_W, 16, ALU slice width; only 16 is supported; the 32-bit ops use 2*ALU_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_cmd  input  3  command: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 ADD32, 110 SUB32, 111 CMP (SUB, result discarded)
req_a  input  32  operand A; the 16-bit ops use [15:0]
req_b  input  32  operand B; the 16-bit ops use [15:0]
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  32  result; [31:16]=0 for 16-bit ops; all 0 for CMP
rsp_cout  output  1  final carry-out (1 = no borrow for SUB)
rsp_overflow  output  1  signed overflow of final pass
rsp_zero  output  1  arithmetic result zero over full op width (valid for CMP too)
alu_a  output  16  to ALU a
alu_b  output  16  to ALU b
alu_cin  output  1  to ALU cin
alu_less  output  1  to ALU less
alu_op  output  3  to ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
alu_result  input  16  from ALU
alu_cout  input  1  from ALU
alu_overflow  input  1  from ALU
alu_zero  input  1  from ALU
alu_set  input  1  from ALU (MSB adder sum)

Behaviour:
- Clocking: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - State IDLE.
  - rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_overflow=0, rsp_zero=0.
  - Captured operands/cmd = 0.
  - req_ready=1 from the first cycle after reset.
- States: IDLE, LO, HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register cmd/a/b and go to LO.
- LO:
  - Drive alu_a=a[15:0] and alu_b=b[15:0].
  - alu_op per cmd; SUB/SUB32/CMP/SLT use op 110/111 with alu_cin=1; all others use alu_cin=0.
  - At clock edge, capture alu_result into result[15:0], plus alu_cout, alu_overflow and alu_zero.
  - Next state HI for ADD32/SUB32, else RESP.
- HI:
  - Drive alu_a=a[31:16] and alu_b=b[31:16].
  - alu_op 010 (ADD32) or 110 (SUB32).
  - alu_cin = cout captured in LO.
  - Capture result[31:16], cout, overflow.
  - zero = zero_lo & alu_zero.
  - Next state RESP.
- RESP:
  - rsp_valid=1.
  - All rsp_* outputs are held stable until rsp_ready is sampled high.
  - When rsp_ready is sampled high, go to IDLE with rsp_valid=0 next cycle.
  - No response is ever dropped or duplicated.
- req_ready is 0 in LO, HI and RESP; there is no request overlap.
- Latency:
  - 16-bit op: request accept edge to rsp_valid = 2 cycles.
  - 32-bit op: 3 cycles.
  - Minimum issue interval is 3 or 4 cycles respectively.
- alu_less = alu_set ^ alu_overflow, combinational. This path contains no loop because set does not depend on less. SLT therefore returns 0x0001 or 0x0000.
- AND/OR: rsp_cout and rsp_overflow are forced 0.
- SLT: rsp_cout and rsp_overflow are forced 0, and rsp_zero reflects result==0.
- In IDLE and RESP, alu_* outputs drive 0 with op 000.
- Undefined encodings do not exist; all 8 cmd values are defined.
- rst asserted in any state returns to IDLE at that edge. Any in-flight op and any pending response are discarded; rsp_valid=0 the next cycle.
- req_valid while not in IDLE is ignored. The requester must hold its request until req_ready.

Optional Feature:
ALU_SEQ_STICKY_OVF_EN
- Defined:
  - Adds input sticky_clr (1 bit) and output sticky_ovf (1 bit).
  - sticky_ovf is set on each RESP handshake whose rsp_overflow=1.
  - sticky_ovf is cleared by sticky_clr or rst; a same-cycle set wins over clear.
  - Reset value 0.
- Undefined: these ports and the sticky register are absent; all other behaviour is identical.

Test Plan:
- ADD, a=0x7FFF, b=0x0001 -> rsp_result=0x00008000, rsp_overflow=1, rsp_cout=0, rsp_zero=0, rsp_valid 2 cycles after accept.
- ADD32, a=0x0001FFFF, b=0x00000001 -> low pass cout=1 fed as high cin; rsp_result=0x00020000, rsp_cout=0, rsp_overflow=0, rsp_zero=0, rsp_valid 3 cycles after accept.
- SUB32, a=0x00000000, b=0x00000001 -> rsp_result=0xFFFFFFFF, rsp_cout=0, rsp_overflow=0; CMP a=0x1234, b=0x1234 -> rsp_result=0, rsp_zero=1, rsp_cout=1.
- SLT, a=0xFFFF, b=0x0001 -> 0x00000001; SLT a=0x8000, b=0x7FFF -> 0x00000001 (overflow-corrected); SLT a=0x0005, b=0x0003 -> 0x00000000.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
- rst pulsed during HI of ADD32 -> next cycle IDLE, rsp_valid=0, all rsp_* 0, no response emitted; a following ADD 0x0002+0x0003 returns 0x00000005.
